// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer: feeds a 4-lane MAC over a valid/ready stream and accumulates its results into a dot product
module mac_dot_sequencer #(
  parameter int MAC_LATENCY = 3,
  parameter int ACC_WIDTH = 32,
  parameter int LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] cfg_len,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [31:0]          in_a,
  input  logic [31:0]          in_b,
  output logic [31:0]          mac_a,
  output logic [31:0]          mac_b,
  input  logic [17:0]          mac_result,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] out_data,
  output logic                 out_overflow
);
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, HOLD} state_t;
  state_t state, nxt;
  logic [LEN_WIDTH-1:0] cnt;
  logic [MAC_LATENCY:0] trk;
  logic [ACC_WIDTH-1:0] acc, ext, sum;
  logic ovf, accept, acc_en, last, add_ov;
  assign accept = in_valid & in_ready;
  assign acc_en = trk[MAC_LATENCY];
  assign last = acc_en & ~|trk[MAC_LATENCY-1:0];
  assign ext = ACC_WIDTH'($signed(mac_result));
  assign sum = acc + ext;
  assign add_ov = (acc[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) & (sum[ACC_WIDTH-1] != acc[ACC_WIDTH-1]);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (start ? (cfg_len == '0 ? HOLD : LOAD) : IDLE) :
          state == LOAD  ? (accept && cnt == LEN_WIDTH'(1) ? DRAIN : LOAD) :
          state == DRAIN ? (last ? HOLD : DRAIN) :
                           (out_ready ? IDLE : HOLD);
  always_comb begin
    busy = state != IDLE;
    in_ready = state == LOAD;
    out_valid = state == HOLD;
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      cnt <= '0;
      trk <= '0;
      acc <= '0;
      ovf <= 1'b0;
      mac_a <= '0;
      mac_b <= '0;
    end else begin
      mac_a <= accept ? in_a : '0;
      mac_b <= accept ? in_b : '0;
      trk <= {trk[MAC_LATENCY-1:0], accept};
      if (state == IDLE && start) begin
        cnt <= cfg_len;
        acc <= '0;
        ovf <= 1'b0;
      end else begin
        if (accept) cnt <= cnt - LEN_WIDTH'(1);
        if (acc_en) begin
          acc <= sum;
          ovf <= ovf | add_ov;
        end
      end
    end
  assign out_data = acc;
  assign out_overflow = ovf;
endmodule

// File: tb/tb_mac_dot_sequencer.sv
// tb_mac_dot_sequencer: table, hand-written and random jobs checked against a behavioural dot-product model
module tb_mac_dot_sequencer;
  localparam int L = 3, AW = 20, LW = 16;
  localparam longint AMAX = (64'sd1 << (AW - 1)) - 1, AMIN = -(64'sd1 << (AW - 1)), AMOD = 64'sd1 << AW;
  logic clk = 0, resetn = 0, start = 0, in_valid = 0, out_ready = 0;
  logic [LW-1:0] cfg_len = '0;
  logic [31:0] in_a = '0, in_b = '0, mac_a, mac_b;
  logic [17:0] mac_result;
  logic busy, in_ready, out_valid, out_overflow;
  logic [AW-1:0] out_data;
  logic signed [17:0] pipe [L];
  int checks = 0, failures = 0;
  logic [31:0] ba [64], bb [64];
  typedef struct {int n; int gap; logic [31:0] a0, b0, a1, b1; logic [AW-1:0] exp; bit ov;} vec_t;
  vec_t vt [7];

  mac_dot_sequencer #(.MAC_LATENCY(L), .ACC_WIDTH(AW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .resetn(resetn), .start(start), .cfg_len(cfg_len), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .mac_a(mac_a), .mac_b(mac_b), .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_overflow(out_overflow)
  );

  always #5 clk = ~clk;

  function automatic int dot(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) s += int'($signed(a[8*i +: 8])) * int'($signed(b[8*i +: 8]));
    return s;
  endfunction

  always @(posedge clk) begin
    pipe[0] <= 18'(dot(mac_a, mac_b));
    for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
  end
  assign mac_result = pipe[L-1];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input int n, output logic [AW-1:0] e, output bit ov);
    longint acc = 0, t;
    ov = 0;
    for (int i = 0; i < n; i++) begin
      t = acc + longint'(dot(ba[i], bb[i]));
      if (t > AMAX || t < AMIN) ov = 1;
      acc = ((t - AMIN + AMOD) % AMOD) + AMIN;
    end
    e = AW'(acc);
  endtask

  task automatic do_job(input int n, input int gap, input logic [AW-1:0] exp, input bit ov, input bit rel);
    int e = 0;
    @(negedge clk);
    start = 1;
    cfg_len = LW'(n);
    out_ready = 0;
    @(negedge clk);
    start = 0;
    chk("busy_after_start", busy, 1);
    for (int i = 0; i < n; i++) begin
      chk("in_ready_load", in_ready, 1);
      in_valid = 1;
      in_a = ba[i];
      in_b = bb[i];
      @(negedge clk);
      e++;
      in_valid = 0;
      if (i < n - 1) repeat (gap) begin
        @(negedge clk);
        e++;
      end
    end
    while (!out_valid && e < 200) begin
      @(negedge clk);
      e++;
    end
    chk("latency", e, n == 0 ? 0 : n + gap * (n - 1) + L + 1);
    chk("out_data", out_data, exp);
    chk("out_overflow", out_overflow, ov);
    if (rel) begin
      out_ready = 1;
      @(negedge clk);
      out_ready = 0;
      chk("idle_after_handshake", busy | out_valid, 0);
    end
  endtask

  initial begin
    logic [AW-1:0] e, d;
    bit ov;
    vt[0] = '{4, 0, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 20'd16, 1'b0};
    vt[1] = '{2, 0, 32'h80808080, 32'h80808080, 32'hFF01FF01, 32'h01010101, 20'h10000, 1'b0};
    vt[2] = '{3, 1, 32'h02020202, 32'h01010101, 32'h02020202, 32'h01010101, 20'd24, 1'b0};
    vt[3] = '{8, 0, 32'h80808080, 32'h80808080, 32'h80808080, 32'h80808080, 20'h80000, 1'b1};
    vt[4] = '{1, 0, 32'h01010101, 32'h01010101, 32'h01010101, 32'h01010101, 20'd4, 1'b0};
    vt[5] = '{0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 20'd0, 1'b0};
    vt[6] = '{3, 0, 32'hFFFFFFFF, 32'h02020202, 32'hFFFFFFFF, 32'h02020202, 20'hFFFE8, 1'b0};
    repeat (5) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_overflow", out_overflow, 0);
    chk("rst_mac_a", mac_a, 0);
    chk("rst_mac_b", mac_b, 0);
    resetn = 1;
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < vt[v].n; i++) begin
        ba[i] = i % 2 ? vt[v].a1 : vt[v].a0;
        bb[i] = i % 2 ? vt[v].b1 : vt[v].b0;
      end
      do_job(vt[v].n, vt[v].gap, vt[v].exp, vt[v].ov, 1);
    end
    for (int i = 0; i < 2; i++) begin
      ba[i] = 32'h03030303;
      bb[i] = 32'h01010101;
    end
    do_job(2, 0, 20'd24, 0, 0);
    d = out_data;
    repeat (5) begin
      @(negedge clk);
      start = 1;
      cfg_len = LW'(3);
      @(negedge clk);
      start = 0;
      chk("bp_out_valid", out_valid, 1);
      chk("bp_busy", busy, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_data_stable", out_data, d);
    end
    @(negedge clk);
    start = 1;
    out_ready = 1;
    @(negedge clk);
    start = 0;
    out_ready = 0;
    chk("hs_start_ignored", busy, 0);
    chk("hs_out_valid", out_valid, 0);
    @(negedge clk);
    start = 1;
    cfg_len = LW'(4);
    @(negedge clk);
    start = 0;
    in_valid = 1;
    in_a = 32'h01010101;
    in_b = 32'h01010101;
    repeat (5) @(negedge clk);
    in_valid = 0;
    chk("pre_rst_acc", out_data, 4);
    #2 resetn = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 0);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_mac_a", mac_a, 0);
    chk("arst_mac_b", mac_b, 0);
    @(negedge clk);
    resetn = 1;
    ba[0] = 32'h01010101;
    bb[0] = 32'h01010101;
    do_job(1, 0, 20'd4, 0, 1);
    repeat (20) begin
      int n, g;
      n = $urandom_range(0, 6);
      g = $urandom_range(0, 2);
      for (int i = 0; i < n; i++) begin
        ba[i] = $urandom;
        bb[i] = $urandom;
      end
      model(n, e, ov);
      do_job(n, g, e, ov, 1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
